// File: rtl/seg_port_pkg.sv
// Shared types and constants for the multiplexed 7-segment serial port transmitter.
package seg_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        WAIT
    } state_t;

    localparam int unsigned STROBE_BIT = 2;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned DIGITS     = 4;

    // One display frame: four nibbles plus their decimal points.
    typedef struct packed {
        logic [3:0]  dp;
        logic [15:0] data;
    } disp_t;

    // gfedcba patterns for hex digits 0..F, active-high.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_port_tx_hex7seg.sv
// Combinational hex nibble to 7-segment pattern decoder with decimal point.
module hex7seg
    import seg_port_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern_c
);

    assign pattern_c = {dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg_port_tx.sv
// Scans four hex digits out to a latching segment driver: value/index, strobe, hold, wait per slot.
module seg_port_tx
    import seg_port_pkg::*;
#(
    parameter int unsigned DIGIT_PERIOD = 1000,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STROBE_CYC   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        run_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    output logic [7:0]  seg_val_o,
    output logic [7:0]  seg_sel_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(SETUP_CYC + STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(DIGIT_PERIOD - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] next_idx, next_idx_nxt, idx_nxt;
    disp_t            shadow, shadow_nxt, active, active_nxt, load_val;
    logic [7:0]       seg_sel_nxt, seg_val_nxt_c, pattern_c;
    logic             busy_nxt, frame_done_nxt;
    logic             setup_entry, slot_end;
    logic [3:0]       nibble;
    logic             dp_sel;

    assign load_val = {dp_i, data_i};

    // Next state, slot timing and frame data selection.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        next_idx_nxt = next_idx;
        idx_nxt      = seg_sel_o[IDX_W-1:0];
        shadow_nxt   = shadow;
        active_nxt   = active;
        setup_entry  = 1'b0;
        slot_end     = (state != IDLE) && (cnt == SLOT_LAST);

        if (load_i) begin
            shadow_nxt = load_val;
        end

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (run_i) begin
                    setup_entry = 1'b1;
                end
            end
            SETUP:  if (cnt == SETUP_LAST)  state_nxt = STROBE;
            STROBE: if (cnt == STROBE_LAST) state_nxt = HOLD;
            HOLD:   state_nxt = WAIT;
            WAIT:   state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase

        // A zero-length WAIT means the slot ends straight out of HOLD.
        if (slot_end) begin
            if (run_i) begin
                setup_entry = 1'b1;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end

        if (setup_entry) begin
            state_nxt    = SETUP;
            cnt_nxt      = '0;
            idx_nxt      = next_idx;
            next_idx_nxt = next_idx + IDX_W'(1);
            if (next_idx == '0) begin
                active_nxt = load_i ? load_val : shadow;
            end
        end

        seg_sel_nxt                 = '0;
        seg_sel_nxt[IDX_W-1:0]      = idx_nxt;
        seg_sel_nxt[STROBE_BIT]     = (state_nxt == STROBE);
        busy_nxt                    = (state_nxt != IDLE);
        frame_done_nxt              = (state_nxt != IDLE) && (cnt_nxt == SLOT_LAST)
                                      && (idx_nxt == IDX_W'(DIGITS - 1));
    end

    assign nibble = active_nxt.data[{idx_nxt, 2'b00} +: 4];
    assign dp_sel = active_nxt.dp[idx_nxt];

    hex7seg u_hex7seg (
        .nibble    (nibble),
        .dp        (dp_sel),
        .pattern_c (pattern_c)
    );

    // Segment value changes only when a new slot begins.
    assign seg_val_nxt_c = setup_entry ? pattern_c : seg_val_o;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            next_idx     <= '0;
            shadow       <= '0;
            active       <= '0;
            seg_val_o    <= '0;
            seg_sel_o    <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            next_idx     <= next_idx_nxt;
            shadow       <= shadow_nxt;
            active       <= active_nxt;
            seg_val_o    <= seg_val_nxt_c;
            seg_sel_o    <= seg_sel_nxt;
            busy_o       <= busy_nxt;
            frame_done_o <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seg_port_tx.sv
// Directed bench for seg_port_tx with a short digit period; a negedge monitor records latches.
module tb_seg_port_tx;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        run_i;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic [7:0]  seg_val_o;
    logic [7:0]  seg_sel_o;
    logic        busy_o;
    logic        frame_done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] lat_val [$];
    logic [1:0] lat_idx [$];
    int         rise_q  [$];
    int         hi_len  [$];
    int         margin_q[$];
    int         hi_cnt   = 0;
    int         fd_cnt   = 0;
    int         hold_bad = 0;
    int         chg_cyc  = 0;
    int         t0;
    logic       strb_d    = 1'b0;
    logic       post_fall = 1'b0;
    logic [9:0] prev_vi   = '0;
    logic [9:0] fall_vi   = '0;

    logic [7:0] exp_a [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    logic [7:0] exp_b [6] = '{8'h5B, 8'h06, 8'h5E, 8'h39, 8'h7C, 8'h77};
    logic [1:0] idx_b [6] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    seg_port_tx #(
        .DIGIT_PERIOD (8),
        .SETUP_CYC    (2),
        .STROBE_CYC   (2)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .run_i        (run_i),
        .data_i       (data_i),
        .dp_i         (dp_i),
        .load_i       (load_i),
        .seg_val_o    (seg_val_o),
        .seg_sel_o    (seg_sel_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Receiver model: latches value/index on each strobe falling edge outside reset.
    always @(negedge Clk) begin : mon
        logic [9:0] vi;
        vi = {seg_val_o, seg_sel_o[1:0]};
        if (post_fall && vi != fall_vi) hold_bad++;
        post_fall = 1'b0;
        if (vi != prev_vi) chg_cyc = cyc;
        prev_vi = vi;
        if (seg_sel_o[2]) begin
            if (!strb_d) begin
                rise_q.push_back(cyc);
                margin_q.push_back(cyc - chg_cyc);
            end
            hi_cnt++;
        end else begin
            if (strb_d && !Reset) begin
                lat_val.push_back(seg_val_o);
                lat_idx.push_back(seg_sel_o[1:0]);
                hi_len.push_back(hi_cnt);
                post_fall = 1'b1;
                fall_vi   = vi;
            end
            hi_cnt = 0;
        end
        if (frame_done_o) fd_cnt++;
        strb_d = seg_sel_o[2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clear_mon();
        lat_val.delete();
        lat_idx.delete();
        rise_q.delete();
        hi_len.delete();
        margin_q.delete();
        fd_cnt   = 0;
        hold_bad = 0;
    endtask

    task automatic wait_lat(input int n, input string tag);
        int k = 0;
        while (lat_val.size() < n && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_reached"}, 32'(lat_val.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy_o && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic wait_idx(input logic [1:0] idx, input string tag);
        int k = 0;
        while (!(busy_o && seg_sel_o[1:0] == idx) && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_idx"}, 32'(seg_sel_o[1:0]), 32'(idx));
    endtask

    initial begin
        Reset  = 1'b1;
        run_i  = 1'b0;
        load_i = 1'b0;
        data_i = '0;
        dp_i   = '0;
        tick(2);
        check("rst_val",  32'(seg_val_o),    0);
        check("rst_sel",  32'(seg_sel_o),    0);
        check("rst_busy", 32'(busy_o),       0);
        check("rst_fd",   32'(frame_done_o), 0);
        Reset = 1'b0;

        // Basic frame 0x1234 and slot timing.
        data_i = 16'h1234;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("a_idle_val", 32'(seg_val_o), 0);
        clear_mon();
        run_i = 1'b1;
        wait_lat(4, "a_lat");
        run_i = 1'b0;
        wait_idle("a_stop");
        check("a_nlat", 32'(lat_val.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("a_val%0d", i), 32'(lat_val[i]), 32'(exp_a[i]));
            check($sformatf("a_idx%0d", i), 32'(lat_idx[i]), 32'(i));
        end
        check("a_rise_gap", 32'(rise_q[1] - rise_q[0]), 8);
        check("a_hi_len",   32'(hi_len[0]), 2);
        check("a_setup",    32'(margin_q[1]), 2);
        check("a_hold",     32'(hold_bad), 0);
        check("a_fd",       32'(fd_cnt), 1);
        check("a_idle_sel", 32'(seg_sel_o), 32'h03);
        check("a_idle_v",   32'(seg_val_o), 32'h06);

        // New data loaded mid-frame only shows from the next digit 0.
        run_i = 1'b1;
        wait_idx(2'd2, "b_find2");
        clear_mon();
        data_i = 16'hABCD;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        wait_lat(6, "b_lat");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b_val%0d", i), 32'(lat_val[i]), 32'(exp_b[i]));
            check($sformatf("b_idx%0d", i), 32'(lat_idx[i]), 32'(idx_b[i]));
        end

        // Drop run in the third cycle of a digit-1 slot.
        wait_idx(2'd1, "c_find1");
        t0 = cyc;
        tick(2);
        run_i = 1'b0;
        wait_idle("c_stop");
        check("c_slot_len", 32'(cyc - t0), 8);
        check("c_idle_idx", 32'(seg_sel_o), 32'h01);
        check("c_fd",       32'(fd_cnt), 2);
        clear_mon();
        run_i = 1'b1;
        wait_lat(1, "c_resume");
        check("c_res_idx", 32'(lat_idx[0]), 2);
        check("c_res_val", 32'(lat_val[0]), 32'h7C);

        // Reset while the strobe is high.
        begin
            int k = 0;
            while (!seg_sel_o[2] && k < 50) begin
                tick();
                k++;
            end
        end
        check("d_strobe_seen", 32'(seg_sel_o[2]), 1);
        clear_mon();
        Reset = 1'b1;
        run_i = 1'b0;
        tick();
        check("d_sel",  32'(seg_sel_o), 0);
        check("d_val",  32'(seg_val_o), 0);
        check("d_busy", 32'(busy_o),    0);
        tick();
        Reset = 1'b0;
        check("d_nlat", 32'(lat_val.size()), 0);

        // Decimal point on digit 3, load bypass on the first digit-0 entry.
        clear_mon();
        data_i = 16'h8888;
        dp_i   = 4'b1000;
        load_i = 1'b1;
        run_i  = 1'b1;
        tick();
        load_i = 1'b0;
        check("e_bypass", 32'(seg_val_o), 32'h7F);
        wait_lat(8, "e_lat");
        run_i = 1'b0;
        wait_idle("e_stop");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("e_val%0d", i), 32'(lat_val[i]), (i % 4 == 3) ? 32'hFF : 32'h7F);
            check($sformatf("e_idx%0d", i), 32'(lat_idx[i]), 32'(i % 4));
        end
        check("e_fd", 32'(fd_cnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
